// File: rtl/sm_trace_monitor.sv
// Execution tracer for the schoolMIPS core: captures {cycle, pc, instr} of retired
// instructions into a circular buffer, freezes on trigger/watchdog, drains via valid/ready.
module sm_trace_monitor #(
    parameter int PC_WIDTH    = 32,
    parameter int INSTR_WIDTH = 32,
    parameter int CYC_WIDTH   = 16,
    parameter int DEPTH       = 16,
    parameter int TIMEOUT     = 120
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     arm,
    input  logic [1:0]                               mode,
    input  logic [PC_WIDTH-1:0]                      trig_pc,
    input  logic                                     ret_valid,
    input  logic [PC_WIDTH-1:0]                      pc,
    input  logic [INSTR_WIDTH-1:0]                   instr,
    input  logic                                     rd_ready,
    output logic                                     rd_valid,
    output logic [CYC_WIDTH+PC_WIDTH+INSTR_WIDTH-1:0] rd_data,
    output logic [$clog2(DEPTH):0]                   count,
    output logic                                     overflow,
    output logic                                     timeout,
    output logic                                     frozen
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = CYC_WIDTH + PC_WIDTH + INSTR_WIDTH;

    typedef enum logic [1:0] {IDLE, CAPTURE, FROZEN} state_t;

    state_t               state, nextState;
    logic [PTR_W-1:0]     wrPtr, rdPtr;
    logic [CNT_W-1:0]     cnt;
    logic [CYC_WIDTH-1:0] cycle;
    logic [ENTRY_W-1:0]   mem [DEPTH];

    logic capturing, isFull, doWrite, doOverwrite, fillStop, pcHit, wdFire, doPop;

    // Capture decisions; mode 3 behaves as circular mode 0.
    always_comb begin
        capturing   = 1'b0;
        isFull      = 1'b0;
        doWrite     = 1'b0;
        doOverwrite = 1'b0;
        fillStop    = 1'b0;
        pcHit       = 1'b0;
        wdFire      = 1'b0;
        doPop       = 1'b0;
        nextState   = state;

        capturing   = (state == CAPTURE) && ret_valid;
        isFull      = (cnt == CNT_W'(DEPTH));
        doWrite     = capturing && ((mode != 2'd1) || !isFull);
        doOverwrite = capturing && (mode != 2'd1) && isFull;
        fillStop    = capturing && (mode == 2'd1) && (cnt == CNT_W'(DEPTH - 1));
        pcHit       = capturing && (mode == 2'd2) && (pc == trig_pc);
        wdFire      = (TIMEOUT != 0) && (state == CAPTURE) && (cycle == CYC_WIDTH'(TIMEOUT - 1));
        doPop       = rd_valid && rd_ready;

        if (arm) begin
            nextState = CAPTURE;
        end else if ((state == CAPTURE) && (fillStop || pcHit || wdFire)) begin
            nextState = FROZEN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Pointers, occupancy, cycle counter and sticky flags; arm clears everything.
    always_ff @(posedge clk) begin
        if (rst || arm) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            cnt      <= '0;
            cycle    <= '0;
            overflow <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            if (doWrite) begin
                wrPtr <= wrPtr + 1'b1;
                if (doOverwrite) begin
                    rdPtr    <= rdPtr + 1'b1;
                    overflow <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
                cnt   <= cnt - 1'b1;
            end
            if ((state == CAPTURE) && (cycle != '1)) begin
                cycle <= cycle + 1'b1;
            end
            if (wdFire) begin
                timeout <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !arm && doWrite) begin
            mem[wrPtr] <= {cycle, pc, instr};
        end
    end

    // Gating by rd_valid keeps rd_data at zero whenever nothing is readable.
    assign rd_valid = (state == FROZEN) && (cnt != '0);
    assign rd_data  = rd_valid ? mem[rdPtr] : '0;
    assign count    = cnt;
    assign frozen   = (state == FROZEN);

endmodule

// File: tb/tb_sm_trace_monitor.sv
// Scoreboard bench for sm_trace_monitor: a queue-based reference model predicts every
// drained entry and the status outputs; a monitor process checks each handshake.
module tb_sm_trace_monitor;

    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 20;
    localparam int ENTRY_W = 16 + 32 + 32;

    logic               clk = 1'b0;
    logic               rst, arm, ret_valid, rd_ready;
    logic [1:0]         mode;
    logic [31:0]        trigPc, pc, instr;
    logic               rd_valid, overflow, timeout, frozen;
    logic [ENTRY_W-1:0] rd_data;
    logic [4:0]         count;

    int testsRun    = 0;
    int testsFailed = 0;

    // Reference model: trace held as a plain queue, state as 0 idle / 1 capture / 2 frozen.
    logic [ENTRY_W-1:0] modelQ[$];
    logic [ENTRY_W-1:0] expQ[$];
    int                 mState;
    int                 mCycle;
    bit                 mOverflow, mTimeout;

    sm_trace_monitor #(
        .PC_WIDTH(32), .INSTR_WIDTH(32), .CYC_WIDTH(16), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .arm(arm), .mode(mode), .trig_pc(trigPc),
        .ret_valid(ret_valid), .pc(pc), .instr(instr), .rd_ready(rd_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .count(count),
        .overflow(overflow), .timeout(timeout), .frozen(frozen)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string name, input logic [127:0] actual, input logic [127:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkVal({tag, " count"}, count, modelQ.size());
        checkVal({tag, " frozen"}, frozen, mState == 2);
        checkVal({tag, " overflow"}, overflow, mOverflow);
        checkVal({tag, " timeout"}, timeout, mTimeout);
        checkVal({tag, " rd_valid"}, rd_valid, (mState == 2) && (modelQ.size() != 0));
    endtask

    task automatic modelStep();
        bit freeze;
        int m;
        if (arm) begin
            modelQ.delete();
            mCycle = 0; mOverflow = 0; mTimeout = 0; mState = 1;
        end else if (mState == 1) begin
            freeze = 0;
            m = (mode == 2'd3) ? 0 : int'(mode);
            if (ret_valid) begin
                if (m == 1) begin
                    if (modelQ.size() < DEPTH) modelQ.push_back({mCycle[15:0], pc, instr});
                    if (modelQ.size() == DEPTH) freeze = 1;
                end else begin
                    if (modelQ.size() == DEPTH) begin
                        void'(modelQ.pop_front());
                        mOverflow = 1;
                    end
                    modelQ.push_back({mCycle[15:0], pc, instr});
                    if (m == 2 && pc == trigPc) freeze = 1;
                end
            end
            if (mCycle == TIMEOUT - 1) begin
                mTimeout = 1;
                freeze   = 1;
            end
            if (mCycle != 65535) mCycle++;
            if (freeze) mState = 2;
        end else if (mState == 2 && rd_ready && modelQ.size() != 0) begin
            expQ.push_back(modelQ.pop_front());
        end
    endtask

    task automatic applyStimulus(input bit a, input bit rv, input logic [31:0] p, input bit rr);
        arm       = a;
        ret_valid = rv;
        pc        = p;
        instr     = $urandom;
        rd_ready  = rr;
        modelStep();
        @(posedge clk);
        #1;
        checkOutput("step");
    endtask

    task automatic doReset();
        rst = 1'b1;
        arm = 1'b0; ret_valid = 1'b0; rd_ready = 1'b0;
        modelQ.delete();
        mState = 0; mCycle = 0; mOverflow = 0; mTimeout = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("reset");
        checkVal("reset rd_data", rd_data, 0);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 120 && modelQ.size() != 0; i++) begin
            applyStimulus(0, 1, $urandom_range(0, 15), $urandom_range(0, 1));
        end
        applyStimulus(0, 0, 0, 0);
        checkVal({tag, " drained entries all seen"}, expQ.size(), 0);
        checkVal({tag, " count after drain"}, count, 0);
    endtask

    // Monitor: every accepted beat must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && !arm && rd_valid && rd_ready) begin
            if (expQ.size() == 0) begin
                testsRun++;
                testsFailed++;
                $display("[TB] FAIL unexpected pop: got %0h, expected no beat", rd_data);
            end else begin
                checkVal("rd_data", rd_data, expQ.pop_front());
            end
        end
    end

    initial begin
        mode = 2'd0; trigPc = '0; pc = '0; instr = '0;
        doReset();

        // Circular capture of pc 0..19, frozen by the watchdog with 16 newest entries.
        applyStimulus(1, 0, 0, 0);
        for (int i = 0; i < 20; i++) applyStimulus(0, 1, i, 0);
        checkVal("t1 count", count, 16);
        checkVal("t1 overflow", overflow, 1);
        checkVal("t1 oldest", rd_data[79:32], {16'd4, 32'd4});
        drain("t1");

        // Stop-when-full.
        mode = 2'd1;
        applyStimulus(1, 0, 0, 0);
        for (int i = 0; i <= 20; i++) applyStimulus(0, 1, i, 0);
        checkVal("t2 count", count, 16);
        checkVal("t2 timeout", timeout, 0);
        drain("t2");

        // PC-match trigger.
        mode = 2'd2; trigPc = 32'd7;
        applyStimulus(1, 0, 0, 0);
        for (int i = 0; i < 10; i++) applyStimulus(0, 1, i, 0);
        checkVal("t3 count", count, 8);
        drain("t3");

        // Sparse retirement, watchdog freeze, toggled reader.
        mode = 2'd0;
        applyStimulus(1, 0, 0, 0);
        for (int i = 0; i < 22; i++) applyStimulus(0, (i % 2) == 0, 100 + i, 0);
        checkVal("t4 timeout", timeout, 1);
        checkVal("t4 count", count, 10);
        drain("t4");

        // arm in the same cycle as a pop.
        mode = 2'd2; trigPc = 32'd3;
        applyStimulus(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, i, 0);
        applyStimulus(1, 0, 0, 1);
        checkVal("t5 count", count, 0);
        checkVal("t5 frozen", frozen, 0);

        // Reset mid-capture, then no capture until re-armed.
        mode = 2'd0;
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, i, 0);
        checkVal("t6 pre-reset count", count, 5);
        doReset();
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, i, 1);
        checkVal("t6 idle count", count, 0);

        // Randomized rounds in every mode.
        for (int r = 0; r < 8; r++) begin
            mode   = 2'($urandom_range(0, 3));
            trigPc = $urandom_range(0, 7);
            applyStimulus(1, 0, 0, 0);
            for (int i = 0; i < 24; i++)
                applyStimulus(0, $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 1));
            drain("rand");
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
